// File: rtl/input_datapath_pkg.sv
// Shared sizes, the skewed-lane type and the lane packing helper for input_datapath.
// Define INPUT_DATAPATH_SKEW_EN to stagger each slot by one byte per slot index.
package input_datapath_pkg;

  localparam int DIM    = 4;
  localparam int BYTE_W = 8;
  localparam int SKEW_W = 56;
  localparam int WORD_W = DIM * BYTE_W;

  localparam logic [2:0] COUNT_MAX = 3'(DIM);
  localparam logic [1:0] LAST_SLOT = 2'(DIM - 1);

`ifdef INPUT_DATAPATH_SKEW_EN
  localparam bit SKEW_EN = 1'b1;
`else
  localparam bit SKEW_EN = 1'b0;
`endif

  typedef logic [SKEW_W-1:0] skew_lane_t;

  // slot is the zero-based slot index; skewing pushes the word down one byte per slot
  function automatic skew_lane_t pack_lane(input logic [WORD_W-1:0] word,
                                           input logic [2:0]        slot);
    skew_lane_t lane;
    lane = {word, {(SKEW_W - WORD_W){1'b0}}};
    return SKEW_EN ? (lane >> (slot * BYTE_W)) : lane;
  endfunction

endpackage

// File: rtl/input_datapath_handshake.sv
// Valid/ready capture register for the incoming 64-bit word plus the
// one-cycle tx_one_done pulse that follows every accepted transfer.
module input_handshake_reg
  import input_datapath_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*WORD_W-1:0]   data_in,
  input  logic                  src_valid,
  input  logic                  dest_ready,
  output logic [2*WORD_W-1:0]   protocol_out,
  output logic                  tx_one_done
);

  logic transfer;

  assign transfer = src_valid & dest_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      protocol_out <= '0;
      tx_one_done  <= 1'b0;
    end else begin
      if (transfer) begin
        protocol_out <= data_in;
      end
      tx_one_done <= transfer;
    end
  end

endmodule

// File: rtl/input_datapath.sv
// Captures A rows / B columns from a 64-bit stream and commits them into four
// packed lanes each; packing is skewed only when INPUT_DATAPATH_SKEW_EN is defined.
module input_datapath
  import input_datapath_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       data_in,
  input  logic              src_valid,
  input  logic              dest_ready,
  input  logic              next_row,
  input  logic              next_col,
  output logic [SKEW_W-1:0] data_out [2:0],
  output logic              load_done,
  output logic              tx_one_done,
  output logic [SKEW_W-1:0] A_r1,
  output logic [SKEW_W-1:0] A_r2,
  output logic [SKEW_W-1:0] A_r3,
  output logic [SKEW_W-1:0] A_r4,
  output logic [SKEW_W-1:0] B_c1,
  output logic [SKEW_W-1:0] B_c2,
  output logic [SKEW_W-1:0] B_c3,
  output logic [SKEW_W-1:0] B_c4
);

  logic [63:0] protocol_out;
  logic [2:0]  row_count;
  logic [2:0]  col_count;
  logic [1:0]  row_sel;
  logic [1:0]  col_sel;
  skew_lane_t  a_slot [DIM];
  skew_lane_t  b_slot [DIM];

  input_handshake_reg u_handshake (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .src_valid    (src_valid),
    .dest_ready   (dest_ready),
    .protocol_out (protocol_out),
    .tx_one_done  (tx_one_done)
  );

  // Commits read protocol_out before this edge's capture lands, so a word
  // arriving together with next_row/next_col is only committed by a later pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_count <= '0;
      col_count <= '0;
      load_done <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        a_slot[i] <= '0;
        b_slot[i] <= '0;
      end
    end else begin
      if (next_row && (row_count < COUNT_MAX)) begin
        a_slot[row_count[1:0]] <= pack_lane(protocol_out[63:32], row_count);
        row_count              <= row_count + 3'd1;
      end
      if (next_col && (col_count < COUNT_MAX)) begin
        b_slot[col_count[1:0]] <= pack_lane(protocol_out[31:0], col_count);
        col_count              <= col_count + 3'd1;
      end
      if ((row_count == COUNT_MAX) && (col_count == COUNT_MAX)) begin
        load_done <= 1'b1;
      end
    end
  end

  // A saturated count of 4 keeps pointing at the last slot
  always_comb begin
    row_sel = (row_count >= COUNT_MAX) ? LAST_SLOT : row_count[1:0];
    col_sel = (col_count >= COUNT_MAX) ? LAST_SLOT : col_count[1:0];
  end

  assign data_out[0] = a_slot[row_sel];
  assign data_out[1] = b_slot[col_sel];
  assign data_out[2] = protocol_out[SKEW_W-1:0];

  assign A_r1 = a_slot[0];
  assign A_r2 = a_slot[1];
  assign A_r3 = a_slot[2];
  assign A_r4 = a_slot[3];
  assign B_c1 = b_slot[0];
  assign B_c2 = b_slot[1];
  assign B_c3 = b_slot[2];
  assign B_c4 = b_slot[3];

endmodule

// File: tb/tb_input_datapath.sv
// Scoreboard bench for input_datapath: stimulus queues expected values, two
// negedge monitors pop and compare them (state checks and transfer pulses).
module tb_input_datapath;
  import input_datapath_pkg::*;

  localparam int K_DO0 = 0, K_DO1 = 1, K_DO2 = 2, K_TX = 3, K_LD = 4;
  localparam int K_RC = 5, K_CC = 6, K_PROT = 7, K_A1 = 8, K_B1 = 12;

  typedef struct {
    int          cyc;
    int          kind;
    string       name;
    logic [63:0] value;
  } chk_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [63:0]       data_in = '0;
  logic              src_valid = 1'b0;
  logic              dest_ready = 1'b0;
  logic              next_row = 1'b0;
  logic              next_col = 1'b0;
  logic [SKEW_W-1:0] data_out [2:0];
  logic              load_done;
  logic              tx_one_done;
  logic [SKEW_W-1:0] A_r1, A_r2, A_r3, A_r4;
  logic [SKEW_W-1:0] B_c1, B_c2, B_c3, B_c4;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  chk_t chk_q [$];
  logic [SKEW_W-1:0] tx_q [$];

  logic [SKEW_W-1:0] exp_a [4];
  logic [SKEW_W-1:0] exp_b [4];
  logic [SKEW_W-1:0] exp_a2_new;
  logic [SKEW_W-1:0] exp_b2_new;

  input_datapath dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .src_valid   (src_valid),
    .dest_ready  (dest_ready),
    .next_row    (next_row),
    .next_col    (next_col),
    .data_out    (data_out),
    .load_done   (load_done),
    .tx_one_done (tx_one_done),
    .A_r1        (A_r1),
    .A_r2        (A_r2),
    .A_r3        (A_r3),
    .A_r4        (A_r4),
    .B_c1        (B_c1),
    .B_c2        (B_c2),
    .B_c3        (B_c3),
    .B_c4        (B_c4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [63:0] get_actual(input int kind);
    case (kind)
      K_DO0:   return {8'h0, data_out[0]};
      K_DO1:   return {8'h0, data_out[1]};
      K_DO2:   return {8'h0, data_out[2]};
      K_TX:    return {63'h0, tx_one_done};
      K_LD:    return {63'h0, load_done};
      K_RC:    return {61'h0, dut.row_count};
      K_CC:    return {61'h0, dut.col_count};
      K_PROT:  return dut.protocol_out;
      K_A1:    return {8'h0, A_r1};
      K_A1+1:  return {8'h0, A_r2};
      K_A1+2:  return {8'h0, A_r3};
      K_A1+3:  return {8'h0, A_r4};
      K_B1:    return {8'h0, B_c1};
      K_B1+1:  return {8'h0, B_c2};
      K_B1+2:  return {8'h0, B_c3};
      K_B1+3:  return {8'h0, B_c4};
      default: return 64'hDEAD_DEAD_DEAD_DEAD;
    endcase
  endfunction

  // Queue a check for the negedge after the next rising edge
  task automatic expect_next(input int kind, input string name, input logic [63:0] value);
    chk_t c;
    c.cyc   = cyc + 1;
    c.kind  = kind;
    c.name  = name;
    c.value = value;
    chk_q.push_back(c);
  endtask

  task automatic apply_stimulus(input logic rst, input logic [63:0] din, input logic sv,
                                input logic dr, input logic nr, input logic nc);
    @(posedge clk);
    #1;
    reset      = rst;
    data_in    = din;
    src_valid  = sv;
    dest_ready = dr;
    next_row   = nr;
    next_col   = nc;
    if (!rst && sv && dr) tx_q.push_back(din[SKEW_W-1:0]);
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      chk_t c;
      c = chk_q.pop_front();
      check_output(c.name, get_actual(c.kind), c.value);
    end
  end

  always @(negedge clk) begin
    if (tx_one_done === 1'b1) begin
      if (tx_q.size() == 0) begin
        check_output("tx_unexpected", {63'h0, tx_one_done}, 64'h0);
      end else begin
        logic [SKEW_W-1:0] e;
        e = tx_q.pop_front();
        check_output("tx_data", {8'h0, data_out[2]}, {8'h0, e});
      end
    end
  end

  initial begin
`ifdef INPUT_DATAPATH_SKEW_EN
    exp_a = '{56'hA1B2C3D4000000, 56'h00A1B2C3D40000, 56'h0000A1B2C3D400, 56'h000000A1B2C3D4};
    exp_b = '{56'hE5F60708000000, 56'h00E5F607080000, 56'h0000E5F6070800, 56'h000000E5F60708};
    exp_a2_new = 56'h00112233440000;
    exp_b2_new = 56'h00556677880000;
`else
    exp_a = '{56'hA1B2C3D4000000, 56'hA1B2C3D4000000, 56'hA1B2C3D4000000, 56'hA1B2C3D4000000};
    exp_b = '{56'hE5F60708000000, 56'hE5F60708000000, 56'hE5F60708000000, 56'hE5F60708000000};
    exp_a2_new = 56'h11223344000000;
    exp_b2_new = 56'h55667788000000;
`endif

    // Reset state
    apply_stimulus(1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_next(K_TX, "reset_tx", 64'h0);
    expect_next(K_LD, "reset_load_done", 64'h0);
    expect_next(K_RC, "reset_row_count", 64'h0);
    expect_next(K_CC, "reset_col_count", 64'h0);
    expect_next(K_DO0, "reset_data_out0", 64'h0);
    expect_next(K_DO1, "reset_data_out1", 64'h0);
    expect_next(K_DO2, "reset_data_out2", 64'h0);
    for (int i = 0; i < 4; i++) begin
      expect_next(K_A1 + i, $sformatf("reset_A_r%0d", i + 1), 64'h0);
      expect_next(K_B1 + i, $sformatf("reset_B_c%0d", i + 1), 64'h0);
    end

    // Valid held without ready: nothing captured
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b0, 64'hA1B2C3D4_E5F60708, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_next(K_DO2, "stall_data_out2", 64'h0);
      expect_next(K_TX, "stall_tx", 64'h0);
    end
    apply_stimulus(1'b0, 64'hA1B2C3D4_E5F60708, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_next(K_TX, "xfer_tx_high", 64'h1);
    expect_next(K_PROT, "xfer_protocol_out", 64'hA1B2C3D4_E5F60708);
    idle();
    expect_next(K_TX, "xfer_tx_low", 64'h0);
    expect_next(K_DO2, "xfer_hold_data_out2", 64'h00B2C3D4_E5F60708);

    // Four paired commits
    for (int k = 1; k <= 4; k++) begin
      apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      expect_next(K_RC, $sformatf("row_count_%0d", k), 64'(k));
      expect_next(K_CC, $sformatf("col_count_%0d", k), 64'(k));
      expect_next(K_A1 + k - 1, $sformatf("A_r%0d", k), {8'h0, exp_a[k-1]});
      expect_next(K_B1 + k - 1, $sformatf("B_c%0d", k), {8'h0, exp_b[k-1]});
    end
    expect_next(K_DO0, "data_out0_sat", {8'h0, exp_a[3]});
    expect_next(K_DO1, "data_out1_sat", {8'h0, exp_b[3]});
    idle();
    expect_next(K_LD, "load_done_set", 64'h1);

    // Fifth commit is ignored
    apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_next(K_RC, "row_count_sat", 64'h4);
    expect_next(K_CC, "col_count_sat", 64'h4);
    expect_next(K_A1 + 3, "A_r4_unchanged", {8'h0, exp_a[3]});
    expect_next(K_A1, "A_r1_unchanged", {8'h0, exp_a[0]});
    expect_next(K_LD, "load_done_sticky", 64'h1);
    idle();
    expect_next(K_LD, "load_done_sticky2", 64'h1);

    // Reset in the middle of a load, with every other input asserted
    apply_stimulus(1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 64'hA1B2C3D4_E5F60708, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_next(K_RC, "midload_row_count", 64'h2);
    expect_next(K_A1 + 1, "midload_A_r2", {8'h0, exp_a[1]});
    apply_stimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_next(K_RC, "rst_row_count", 64'h0);
    expect_next(K_CC, "rst_col_count", 64'h0);
    expect_next(K_A1, "rst_A_r1", 64'h0);
    expect_next(K_A1 + 1, "rst_A_r2", 64'h0);
    expect_next(K_LD, "rst_load_done", 64'h0);
    expect_next(K_TX, "rst_tx", 64'h0);
    expect_next(K_DO2, "rst_data_out2", 64'h0);

    // Transfer on the same edge as a commit: commit sees the old word
    apply_stimulus(1'b0, 64'hA1B2C3D4_E5F60708, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 64'h11223344_55667788, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_next(K_A1, "same_edge_A_r1", {8'h0, exp_a[0]});
    expect_next(K_B1, "same_edge_B_c1", {8'h0, exp_b[0]});
    expect_next(K_DO2, "same_edge_data_out2", 64'h00223344_55667788);
    expect_next(K_TX, "same_edge_tx", 64'h1);
    apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_next(K_A1 + 1, "new_word_A_r2", {8'h0, exp_a2_new});
    expect_next(K_B1 + 1, "new_word_B_c2", {8'h0, exp_b2_new});
    expect_next(K_RC, "new_word_row_count", 64'h2);
    expect_next(K_TX, "new_word_tx_low", 64'h0);

    repeat (3) idle();
    @(negedge clk);
    #1;
    while (chk_q.size() > 0) begin
      chk_t c;
      c = chk_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s: never compared, expected %h", c.name, c.value);
    end
    while (tx_q.size() > 0) begin
      logic [SKEW_W-1:0] e;
      e = tx_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL tx_missing: no tx_one_done pulse, expected data %h", e);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
